// File: rtl/bk_adder_operand_stage.sv
// Operand/result stage around a 12-bit Brent-Kung adder: handshake in, settle, handshake out.
// Ports: clk/rst_n, in_* handshake, adder_in/adder_sum bus, out_* handshake, clr, txn/carry stats.
module bk_adder_operand_stage #(
  parameter int W             = 12,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [2*W-1:0]   adder_in,
  input  logic [W:0]       adder_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  input  logic             clr,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] carry_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [W:0]       sum_q, sum_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] car_q, car_d;

  logic accept;
  logic out_hs;

  assign out_valid   = (state_q == HOLD);
  assign in_ready    = (state_q == IDLE) |
                       ((state_q == HOLD) & out_ready);
  assign accept      = in_valid & in_ready;
  assign out_hs      = out_valid & out_ready;
  assign out_sum     = sum_q;
  assign txn_count   = txn_q;
  assign carry_count = car_q;

  // Bit-interleaved adder bus: even bits carry A, odd bits carry B.
  for (genvar i = 0; i < W; i++) begin : g_bus
    assign adder_in[2*i]   = a_q[i];
    assign adder_in[2*i+1] = b_q[i];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          sum_d   = adder_sum;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = in_valid ? SETTLE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Operand load is shared by the IDLE and HOLD accept paths.
    if (accept) begin
      a_d   = in_a;
      b_d   = in_b;
      cnt_d = 4'(SETTLE_CYCLES - 1);
    end
  end

  always_comb begin
    txn_d = txn_q;
    car_d = car_q;
    if (clr) begin
      txn_d = '0;
      car_d = '0;
    end else if (out_hs) begin
      txn_d = txn_q + CNT_W'(1);
      if (sum_q[W] && (car_q != '1)) begin
        car_d = car_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      txn_q   <= '0;
      car_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      txn_q   <= txn_d;
      car_q   <= car_d;
    end
  end

endmodule

// File: doc/bk_adder_operand_stage.md
# bk_adder_operand_stage

Sequential front/back-end stage wrapped around the combinational 12-bit Brent-Kung adder. It accepts operand pairs over a valid/ready handshake and drives them onto the adder's 24-bit bit-interleaved input bus, holding them stable. After a programmable settle time it captures the 13-bit adder result and presents it downstream on a valid/ready handshake. It also keeps transaction and carry-out statistics.

## Interface
Parameters:
- W, 12, operand width; adder bus is 2W bits, result is W+1 bits
- SETTLE_CYCLES, 1, cycles the adder inputs are held before the result is captured; legal range 1..15
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept an operand pair
- in_a  in  W  operand A
- in_b  in  W  operand B
- adder_in  out  2W  to adder INPUTS bus: adder_in[2i]=a[i], adder_in[2i+1]=b[i]
- adder_sum  in  W+1  from adder OUTS bus (OUTS[W] is carry-out)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  W+1  captured result
- clr  in  1  synchronous clear of statistics counters
- txn_count  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W
- carry_count  out  CNT_W  completed handshakes with out_sum[W]=1, saturates at all-ones

## Operation
- Reset (async, rst_n=0): state IDLE; operand regs, adder_in, out_sum, settle counter, txn_count, carry_count all 0; out_valid=0; in_ready=1 (combinational from IDLE).
- FSM states IDLE, SETTLE, HOLD.
- IDLE: in_ready=1, out_valid=0. If in_valid: load operand regs from in_a/in_b, load cnt=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: in_ready=0, out_valid=0. If cnt==0: out_sum<=adder_sum, go to HOLD. Else cnt<=cnt-1.
- HOLD: out_valid=1, in_ready=out_ready. If out_ready and in_valid: load new operands, load cnt, go to SETTLE. If out_ready and !in_valid: go to IDLE. If !out_ready: stay; out_sum and operand regs are frozen.
- adder_in is a pure rewire of the operand registers; it changes only on an input handshake.
- Output handshake (out_valid & out_ready): txn_count+1 (wrap); if out_sum[W]=1, carry_count+1 unless already all-ones.
- clr=1: both counters go to 0 that edge; clr wins over a simultaneous handshake increment.
- in_a/in_b are ignored when no input handshake occurs; in_valid may drop without an accept (no protocol penalty).

## Timing
- Input accepted at edge k -> adder_in carries new operands from edge k; result captured at edge k+SETTLE_CYCLES; out_valid high from that edge on.
- Latency accept->out_valid = SETTLE_CYCLES cycles. Sustained throughput with out_ready=1 and in_valid=1: one result per SETTLE_CYCLES+1 cycles.
- in_ready depends combinationally on state and out_ready only; there is no path from in_valid to in_ready.
- out_valid, out_sum, adder_in, txn_count and carry_count are registered outputs.
- out_valid, once high, stays high with stable out_sum until out_ready is sampled high.
- Reset asserted mid-SETTLE or in HOLD: the pending result is discarded. After release the stage is in IDLE with in_ready=1.

## Test plan
- Reset: rst_n low for 3 cycles mid-SETTLE -> out_valid=0, adder_in=0, counters=0, in_ready=1 immediately after the async assertion.
- Single add, SETTLE_CYCLES=1, adder model attached: a=0xFFF, b=0x001 accepted at edge 0 -> adder_in=0x555557, out_valid high after edge 1, out_sum=0x1000; on handshake txn_count=1, carry_count=1.
- Backpressure: a=0x123, b=0x456, out_ready low for 5 cycles -> out_valid held, out_sum=0x579 stable, in_ready=0 throughout; counters unchanged until the handshake.
- Back-to-back, SETTLE_CYCLES=3: 4 pairs with in_valid and out_ready tied high -> results every 4 cycles in order; no drops or duplicates; txn_count=4.
- Clear collision: clr=1 on the same edge as a carry-producing handshake -> txn_count=0 and carry_count=0 on the next cycle.
- Saturation/wrap, CNT_W=4: 17 handshakes all with carry -> carry_count=0xF, txn_count=0x1.
